// File: rtl/pipe_readout_fsm.sv
// ---------------------------------------------------------------------------
// pipe_readout_fsm
//
// Read-side controller for the sample pipeline. Each accepted trigger starts
// a fixed-length capture of NSAMP valid samples from the delayed pipeline
// output. The captured samples, followed by an optional trailer word that
// carries the event number, are written into the downstream event buffer.
// Completed events and rejected triggers are counted.
//
// Build option:
//   PIPE_RO_TRAILER_EN  defined   -> trailer word (event number, OUT_LAST=1)
//                                    follows the last sample.
//                       undefined -> no trailer; OUT_LAST marks sample NSAMP.
//
// Parameters:
//   NSAMP  samples per trigger (1..255)
//   DW     sample / output word width (8..24)
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-low reset
//   RUN        pipeline running
//   TRIG       trigger pulse
//   PIPE_DV    PIPE_DO valid
//   PIPE_DO    delayed pipeline sample
//   OUT_AFULL  event buffer cannot take a full event
//   OUT_WE     event buffer write strobe          (registered)
//   OUT_DATA   sample or trailer word             (registered)
//   OUT_LAST   final word of an event             (registered)
//   BUSY       state is not IDLE                  (registered)
//   ABORT      capture truncated by RUN dropping  (registered)
//   EVT_CNT    completed events, wraps            (registered)
//   LOST_CNT   rejected triggers, saturates       (registered)
// ---------------------------------------------------------------------------
module pipe_readout_fsm #(
  parameter int unsigned NSAMP = 8,
  parameter int unsigned DW    = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          RUN,
  input  logic          TRIG,
  input  logic          PIPE_DV,
  input  logic [DW-1:0] PIPE_DO,
  input  logic          OUT_AFULL,
  output logic          OUT_WE,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_LAST,
  output logic          BUSY,
  output logic          ABORT,
  output logic [23:0]   EVT_CNT,
  output logic [7:0]    LOST_CNT
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned EVT_W  = 24;
  localparam int unsigned LOST_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
`ifdef PIPE_RO_TRAILER_EN
  localparam logic [1:0] ST_TRAILER = 2'd2;
`endif

  localparam logic [CNT_W-1:0]  SAMP_TARGET = CNT_W'(NSAMP);
  localparam logic [LOST_W-1:0] LOST_MAX    = '1;

  // State, sample counter and registered outputs
  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              out_we_q,   out_we_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q,     busy_d;
  logic              abort_q,    abort_d;
  logic [EVT_W-1:0]  evt_cnt_q,  evt_cnt_d;
  logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;

  logic              lost_inc;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_we_d   = 1'b0;
    out_data_d = out_data_q;
    out_last_d = 1'b0;
    abort_d    = 1'b0;
    evt_cnt_d  = evt_cnt_q;
    lost_inc   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (TRIG) begin
          // Buffer-space check happens only here, never during a capture
          if (RUN && !OUT_AFULL) begin
            state_d = ST_CAPTURE;
            cnt_d   = '0;
          end else begin
            lost_inc = 1'b1;
          end
        end
      end

      ST_CAPTURE: begin
        // Triggers are not queued while an event is in flight
        lost_inc = TRIG;
        if (!RUN) begin
          // Losing RUN beats both the sample write and event completion
          state_d = ST_IDLE;
          abort_d = 1'b1;
        end else if (PIPE_DV) begin
          out_we_d   = 1'b1;
          out_data_d = PIPE_DO;
          cnt_d      = cnt_inc;
          if (cnt_inc == SAMP_TARGET) begin
`ifdef PIPE_RO_TRAILER_EN
            state_d = ST_TRAILER;
`else
            state_d    = ST_IDLE;
            out_last_d = 1'b1;
            evt_cnt_d  = evt_cnt_q + EVT_W'(1);
`endif
          end
        end
      end

`ifdef PIPE_RO_TRAILER_EN
      ST_TRAILER: begin
        lost_inc = TRIG;
        state_d  = ST_IDLE;
        if (!RUN) begin
          abort_d = 1'b1;
        end else begin
          // Trailer carries the event number before this event is counted
          out_we_d   = 1'b1;
          out_data_d = evt_cnt_q[DW-1:0];
          out_last_d = 1'b1;
          evt_cnt_d  = evt_cnt_q + EVT_W'(1);
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);

    if (lost_inc && (lost_cnt_q != LOST_MAX)) begin
      lost_cnt_d = lost_cnt_q + LOST_W'(1);
    end else begin
      lost_cnt_d = lost_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_we_q   <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
      evt_cnt_q  <= '0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_we_q   <= out_we_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
      evt_cnt_q  <= evt_cnt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign OUT_WE   = out_we_q;
  assign OUT_DATA = out_data_q;
  assign OUT_LAST = out_last_q;
  assign BUSY     = busy_q;
  assign ABORT    = abort_q;
  assign EVT_CNT  = evt_cnt_q;
  assign LOST_CNT = lost_cnt_q;

endmodule

// File: doc/pipe_readout_fsm.md
# pipe_readout_fsm

Read-side controller for the sample pipeline: once the start sequencer has the pipeline running, this block turns each trigger into a fixed-length capture of the delayed pipeline output stream. It writes the captured samples, followed by an optional trailer word, into the downstream event buffer, and it counts events and lost triggers. It sits between the pipeline memory output and the event buffer write port.

## Interface
- NSAMP, 8: samples captured per trigger; legal range 1..255.
- DW, 12: sample and output data width; legal range 8..24.
- CLK  input  1  single clock; all logic is on its rising edge.
- RST  input  1  synchronous, active-low reset.
- RUN  input  1  pipeline running; high while the pipeline read enable is active.
- TRIG  input  1  trigger, one-cycle pulse.
- PIPE_DV  input  1  PIPE_DO is valid this cycle.
- PIPE_DO  input  DW  delayed sample from the pipeline memory.
- OUT_AFULL  input  1  event buffer cannot accept a full event.
- OUT_WE  output  1  write strobe to the event buffer.
- OUT_DATA  output  DW  sample or trailer word.
- OUT_LAST  output  1  marks the final word of an event.
- BUSY  output  1  high when the state is not IDLE.
- ABORT  output  1  one-cycle pulse when a capture is truncated.
- EVT_CNT  output  24  completed events; wraps modulo 2^24.
- LOST_CNT  output  8  rejected triggers; saturates at 255.

## Operation
- States are IDLE, CAPTURE and TRAILER.
- IDLE -> CAPTURE when TRIG=1, RUN=1 and OUT_AFULL=0. The sample counter clears to 0.
- IDLE with TRIG=1 and (RUN=0 or OUT_AFULL=1): state stays IDLE and LOST_CNT increments.
- TRIG while in CAPTURE or TRAILER: the trigger is ignored and LOST_CNT increments. Triggers are never queued.
- CAPTURE: each cycle with PIPE_DV=1 writes PIPE_DO and increments the sample counter. Cycles with PIPE_DV=0 write nothing and do not advance the count.
- When the counter reaches NSAMP, the state moves to TRAILER, or straight to IDLE if the trailer is compiled out (see Configuration).
- TRAILER: writes one word, OUT_DATA = EVT_CNT[DW-1:0] (the value before the increment), with OUT_LAST=1. EVT_CNT increments. Next state is IDLE.
- RUN=0 in CAPTURE or TRAILER: the state goes to IDLE next cycle and ABORT pulses. No trailer is written and EVT_CNT is unchanged. If PIPE_DV=1 in that same cycle, the sample is still not written.
- RUN=0 takes priority over sample completion in the same cycle.
- Sample counter is 8 bits and clears on every IDLE -> CAPTURE transition.
- LOST_CNT holds at 255 and does not wrap.

## Timing
- Reset values: all outputs are 0 (OUT_WE, OUT_DATA, OUT_LAST, BUSY, ABORT, EVT_CNT, LOST_CNT) and the state is IDLE.
- Reset takes effect at the first CLK edge with RST=0, including in the middle of a capture.
- All outputs are registered.
- A sample accepted at edge k appears as OUT_WE=1 with OUT_DATA=sample after edge k+1, i.e. one cycle of latency.
- TRIG accepted at edge k: the state is CAPTURE after edge k. The first sample eligible for capture is the one with PIPE_DV=1 at edge k+1; the sample present alongside TRIG itself is not captured.
- With PIPE_DV continuously high and the trailer enabled, an event occupies NSAMP+1 consecutive OUT_WE cycles, and BUSY is high for NSAMP+1 cycles.
- The earliest next acceptable TRIG is at the edge where the state has returned to IDLE.
- OUT_AFULL is checked only at trigger acceptance; it is ignored during a capture.
- ABORT, OUT_WE and OUT_LAST are single-cycle pulses per word or event.

## Configuration
- PIPE_RO_TRAILER_EN defined: TRAILER state present, the trailer word is written, OUT_LAST is set on the trailer, and EVT_CNT increments at TRAILER.
- PIPE_RO_TRAILER_EN undefined: no TRAILER state. OUT_LAST is set on sample NSAMP, EVT_CNT increments when that sample is written, and the state returns to IDLE directly. An event is exactly NSAMP words.

## Test plan
- Trailer enabled, NSAMP=8, DW=12, RUN=1, PIPE_DV=1 with PIPE_DO counting 0x100 upward, TRIG at cycle 10 -> 8 writes starting at cycle 12, then trailer 0x000 with OUT_LAST=1; EVT_CNT=1; BUSY high for 9 cycles.
- PIPE_DV toggling 1,0,1,0 during a capture -> exactly 8 sample writes spread over about 16 cycles, no gaps-filled data, trailer follows the last sample.
- TRIG at cycles 10, 12 and 19 (NSAMP=8) -> one event; LOST_CNT=2; the event content is unchanged.
- RUN dropped after 3 samples -> 3 writes, ABORT pulses once, no OUT_LAST, EVT_CNT unchanged; a later TRIG is accepted normally.
- OUT_AFULL=1 at TRIG -> no writes and LOST_CNT increments; 300 rejected triggers -> LOST_CNT=255.
- RST=0 in the middle of a capture -> all outputs 0 after the next edge; build without PIPE_RO_TRAILER_EN -> 8 writes per event with OUT_LAST on the 8th.
